branch_pred_table: RTL and testbench



---
 rtl/branch_pred_table_pkg.sv | 17 +
 rtl/branch_pred_table_if.sv | 30 +++
 rtl/branch_pred_table_counter_next.sv | 22 ++
 rtl/branch_pred_table.sv | 68 ++++++
 tb/tb_branch_pred_table.sv | 137 +++++++++++++
 5 files changed

// File: rtl/branch_pred_table_pkg.sv
// Shared types and constants for the branch prediction table.
package branch_pred_table_pkg;

  typedef logic [31:0] word_t;

  // 2-bit predictor state; bit 1 is the taken prediction.
  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bpt_state_t;

  localparam int unsigned BPT_IDX_W   = 11;
  localparam int unsigned BPT_ENTRIES = 2 ** BPT_IDX_W;

endpackage

// File: rtl/branch_pred_table_if.sv
// Fetch/resolve signal bundle for the branch prediction table.
interface bpt_if #(
  parameter int unsigned PC_W = 32
);

  logic [PC_W-1:0] pc_fetch;
  logic            taken_fetch;
  logic [PC_W-1:0] pc_res;
  logic            taken_res;
  logic            enable_res;

  // Pipeline side: drives PCs and resolve outcome, consumes the prediction.
  modport master (
    output pc_fetch,
    output pc_res,
    output taken_res,
    output enable_res,
    input  taken_fetch
  );

  // Table side.
  modport slave (
    input  pc_fetch,
    input  pc_res,
    input  taken_res,
    input  enable_res,
    output taken_fetch
  );

endinterface

// File: rtl/branch_pred_table_counter_next.sv
// Combinational next-state function of one 2-bit hysteresis predictor.
module bpt_counter_next
  import branch_pred_table_pkg::*;
(
  input  bpt_state_t cur_i,
  input  logic       taken_i,
  output bpt_state_t nxt_o
);

  // A weak state that mispredicts drops to the strong state of the other direction.
  always_comb begin
    nxt_o = SNT;
    unique case (cur_i)
      SNT: nxt_o = taken_i ? WNT : SNT;
      WNT: nxt_o = taken_i ? ST  : SNT;
      WT:  nxt_o = taken_i ? ST  : SNT;
      ST:  nxt_o = taken_i ? ST  : WT;
      default: nxt_o = SNT;
    endcase
  end

endmodule

// File: rtl/branch_pred_table.sv
// Direct-mapped table of 2-bit branch predictors indexed by PC[IDX_W+1:2].
// Optional macro BPT_BYPASS_EN forwards a same-cycle update to the fetch read.
module branch_pred_table
  import branch_pred_table_pkg::*;
#(
  parameter int unsigned PC_W        = 32,
  parameter int unsigned IDX_W       = BPT_IDX_W,
  parameter int unsigned NUM_ENTRIES = 2 ** IDX_W
) (
  input logic    CLK,
  input logic    nRST,
  bpt_if.slave   bus
);

  bpt_state_t state_q [NUM_ENTRIES];

  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  bpt_state_t       fetch_state;
  bpt_state_t       res_state;
  bpt_state_t       res_next;

  assign fetch_idx   = bus.pc_fetch[IDX_W+1:2];
  assign res_idx     = bus.pc_res[IDX_W+1:2];
  assign fetch_state = state_q[fetch_idx];
  assign res_state   = state_q[res_idx];

  // Byte-offset and alias bits never influence the table.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{bus.pc_fetch[PC_W-1:IDX_W+2], bus.pc_fetch[1:0],
                            bus.pc_res[PC_W-1:IDX_W+2], bus.pc_res[1:0]};

  bpt_counter_next u_res_next (
    .cur_i   (res_state),
    .taken_i (bus.taken_res),
    .nxt_o   (res_next)
  );

  // Table storage: synchronous clear has priority over the single-entry update.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      for (int unsigned i = 0; i < NUM_ENTRIES; i++) begin
        state_q[i] <= SNT;
      end
    end else if (bus.enable_res) begin
      state_q[res_idx] <= res_next;
    end
  end

`ifdef BPT_BYPASS_EN
  logic fwd_hit;
  assign fwd_hit = bus.enable_res && (fetch_idx == res_idx);

  // Write-through: a colliding update is seen by fetch in the same cycle.
  always_comb begin
    bus.taken_fetch = fetch_state[1];
    if (fwd_hit) begin
      bus.taken_fetch = res_next[1];
    end
  end
`else
  // Same-index read returns the pre-update state.
  always_comb begin
    bus.taken_fetch = fetch_state[1];
  end
`endif

endmodule

// File: tb/tb_branch_pred_table.sv
// Scoreboard bench for branch_pred_table; honours BPT_BYPASS_EN when defined.
module tb_branch_pred_table;

  logic CLK;
  logic nRST;

  bpt_if #(.PC_W(32)) bus ();

  branch_pred_table dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int unsigned n_checks;
  int unsigned n_pass;
  logic        exp_q [$];
  logic [1:0]  model [2048];

  task automatic check(input string tag, input logic obs, input logic exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b", tag, obs, exp);
  endtask

  function automatic logic [1:0] model_next(input logic [1:0] cur, input logic t);
    if (t) return (cur == 2'b00) ? 2'b01 : 2'b11;
    else   return (cur == 2'b11) ? 2'b10 : 2'b00;
  endfunction

  function automatic logic [10:0] idx_of(input logic [31:0] pc);
    return pc[12:2];
  endfunction

  // One clock: drive at negedge, push expectation, compare before posedge, advance model.
  task automatic step(input string tag, input logic [31:0] pc_f, input logic [31:0] pc_r,
                      input logic t, input logic en, input logic rst_n);
    logic exp_v;
    logic got_v;
    bus.pc_fetch  = pc_f;
    bus.pc_res    = pc_r;
    bus.taken_res = t;
    bus.enable_res = en;
    nRST          = rst_n;
    exp_v = model[idx_of(pc_f)][1];
`ifdef BPT_BYPASS_EN
    if (en && idx_of(pc_f) == idx_of(pc_r))
      exp_v = model_next(model[idx_of(pc_r)], t)[1];
`endif
    exp_q.push_back(exp_v);
    #2;
    got_v = bus.taken_fetch;
    check(tag, got_v, exp_q.pop_front());
    @(posedge CLK);
    if (!rst_n) begin
      for (int i = 0; i < 2048; i++) model[i] = 2'b00;
    end else if (en) begin
      model[idx_of(pc_r)] = model_next(model[idx_of(pc_r)], t);
    end
    @(negedge CLK);
  endtask

  task automatic fetch_sweep(input string tag);
    for (int a = 0; a <= 8188; a += 4) step(tag, 32'(a), 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic train_sweep(input string tag, input logic t);
    for (int a = 0; a <= 8188; a += 4) step(tag, 32'(a), 32'(a), t, 1'b1, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic seq_t [8];
    n_checks = 0;
    n_pass   = 0;
    for (int i = 0; i < 2048; i++) model[i] = 2'b00;
    bus.pc_fetch = '0; bus.pc_res = '0; bus.taken_res = 1'b0; bus.enable_res = 1'b0;
    nRST = 1'b0;
    @(negedge CLK);
    @(posedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    fetch_sweep("reset_sweep");
    train_sweep("train_t1", 1'b1);
    fetch_sweep("after_t1");
    train_sweep("train_t2", 1'b1);
    fetch_sweep("after_t2");
    train_sweep("train_n1", 1'b0);
    fetch_sweep("after_n1");
    train_sweep("train_n2", 1'b0);
    fetch_sweep("after_n2");

    // Hysteresis at 0x40: T,T,T,N,T,N,N,N; neighbour 0x44 watched while updating.
    seq_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 8; k++) begin
      step("hyst_nbr", 32'h44, 32'h40, seq_t[k], 1'b1, 1'b1);
      step("hyst_pred", 32'h40, 32'h0, 1'b0, 1'b0, 1'b1);
    end
    step("hyst_nbr_final", 32'h44, 32'h0, 1'b0, 1'b0, 1'b1);

    // Aliasing and ignored byte offset.
    step("alias_upd", 32'h0, 32'h2004, 1'b1, 1'b1, 1'b1);
    step("alias_upd", 32'h0, 32'h2004, 1'b1, 1'b1, 1'b1);
    step("alias_0004", 32'h0004, 32'h0, 1'b0, 1'b0, 1'b1);
    step("alias_0007", 32'h0007, 32'h0, 1'b0, 1'b0, 1'b1);
    step("alias_2004", 32'h2004, 32'h0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 10; k++)
      step("en_off_hold", 32'h0004, 32'h2004, k[0], 1'b0, 1'b1);
    step("en_off_final", 32'h0005, 32'h0, 1'b0, 1'b0, 1'b1);

    // Same-cycle read/write at 0x100 from state 01.
    step("rst_pulse", 32'h100, 32'h100, 1'b1, 1'b1, 1'b0);
    step("same_prep", 32'h0, 32'h100, 1'b1, 1'b1, 1'b1);
    step("same_cycle", 32'h100, 32'h100, 1'b1, 1'b1, 1'b1);
    step("same_next", 32'h100, 32'h0, 1'b0, 1'b0, 1'b1);

    // Reset asserted in the middle of a taken sweep.
    train_sweep("pre_mid", 1'b1);
    for (int a = 0; a <= 8188; a += 4)
      step("mid_sweep", 32'(a), 32'(a), 1'b1, 1'b1, (a == 4000) ? 1'b0 : 1'b1);
    fetch_sweep("after_mid_rst");
    step("mid_rst_0x10", 32'h10, 32'h0, 1'b0, 1'b0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
